// File: rtl/network_sink_serial.sv
// Buffers network frames in a DEPTH-entry FIFO and serialises each one LSB-first onto a valid/ready word stream.
// Optional feature macro NETWORK_SINK_TSTAMP_EN prefixes every frame with a timestep header word.
module network_sink_serial #(
  parameter int NUM_OUT   = 20,
  parameter int SNK_WIDTH = 8,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 net_valid,
  output logic                 net_ready,
  input  logic [NUM_OUT-1:0]   net_out,
  input  logic                 snk_ready,
  output logic                 snk_valid,
  output logic [SNK_WIDTH-1:0] snk,
  output logic                 snk_last
);

  localparam int NW = (NUM_OUT + SNK_WIDTH - 1) / SNK_WIDTH;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

`ifdef NETWORK_SINK_TSTAMP_EN
  localparam state_t FIRST = HDR;
`else
  localparam state_t FIRST = DATA;
`endif

  state_t                  state;
  logic [IW-1:0]           idx;
  logic [PW-1:0]           head;
  logic [PW-1:0]           tail;
  logic [CW-1:0]           count;
  logic [CW-1:0]           count_next;
  logic                    run;
  logic                    push;
  logic                    pop;
  logic [NUM_OUT-1:0]      mem [DEPTH];
  logic [NW*SNK_WIDTH-1:0] padded;
`ifdef NETWORK_SINK_TSTAMP_EN
  logic [SNK_WIDTH-1:0]    tstamp;
  logic [SNK_WIDTH-1:0]    ts_mem [DEPTH];
`endif

  // run keeps net_ready low until the first edge after reset release
  assign net_ready  = run && (count < FULL);
  assign push       = net_valid && net_ready;
  assign pop        = (state == DATA) && snk_ready && (idx == LAST_IDX);
  assign count_next = count + CW'(push) - CW'(pop);

  assign snk_valid = (state != IDLE);
  assign snk_last  = (state == DATA) && (idx == LAST_IDX);

  always_comb begin
    padded              = '0;
    padded[NUM_OUT-1:0] = mem[head];
    snk                 = '0;
    case (state)
      DATA:    snk = padded[int'(idx)*SNK_WIDTH +: SNK_WIDTH];
`ifdef NETWORK_SINK_TSTAMP_EN
      HDR:     snk = ts_mem[head];
`endif
      default: snk = '0;
    endcase
  end

  // frame storage carries no reset; validity is tracked by count/state
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= net_out;
`ifdef NETWORK_SINK_TSTAMP_EN
      ts_mem[tail] <= tstamp;
`endif
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= IDLE;
      idx   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      run   <= 1'b0;
`ifdef NETWORK_SINK_TSTAMP_EN
      tstamp <= '0;
`endif
    end else begin
      run   <= 1'b1;
      count <= count_next;
      if (push) begin
        tail <= tail + PW'(1);
`ifdef NETWORK_SINK_TSTAMP_EN
        tstamp <= tstamp + SNK_WIDTH'(1);
`endif
      end
      if (pop)
        head <= head + PW'(1);
      case (state)
        IDLE: if (push) state <= FIRST;
        HDR:  if (snk_ready) state <= DATA;
        DATA: begin
          if (snk_ready) begin
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= (count_next != '0) ? FIRST : IDLE;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_network_sink_serial.sv
// Scoreboard bench for network_sink_serial: accepted frames are expanded into expected words, a monitor pops and compares.
// Headers are modelled when NETWORK_SINK_TSTAMP_EN is defined.
module tb_network_sink_serial;

  localparam int NUM_OUT = 20;
  localparam int SW      = 8;
  localparam int DEPTH   = 4;
  localparam int NW      = (NUM_OUT + SW - 1) / SW;
`ifdef NETWORK_SINK_TSTAMP_EN
  localparam int WPF = NW + 1;
`else
  localparam int WPF = NW;
`endif

  logic               clk = 1'b0;
  logic               arst = 1'b1;
  logic               net_valid = 1'b0;
  logic               net_ready;
  logic [NUM_OUT-1:0] net_out = '0;
  logic               snk_ready = 1'b0;
  logic               snk_valid;
  logic [SW-1:0]      snk;
  logic               snk_last;

  network_sink_serial #(.NUM_OUT(NUM_OUT), .SNK_WIDTH(SW), .DEPTH(DEPTH)) dut (
    .clk(clk), .arst(arst), .net_valid(net_valid), .net_ready(net_ready), .net_out(net_out),
    .snk_ready(snk_ready), .snk_valid(snk_valid), .snk(snk), .snk_last(snk_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] w;
    logic          l;
  } exp_t;

  exp_t    exp_q[$];
  int      nvec = 0;
  int      nerr = 0;
  int      fcount = 0;
  int      popped = 0;
  int      ts_m = 0;
  bit      mon_en = 1'b0;
  bit      hold_pend = 1'b0;
  logic [SW-1:0] prev_snk;
  logic          prev_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frames counted in flight, each accepted frame becomes its list of words
  always @(negedge clk) begin
    if (mon_en && !arst) begin
      check("net_ready", 32'(net_ready), 32'(fcount < DEPTH));
      if (hold_pend) begin
        check("hold_valid", 32'(snk_valid), 32'd1);
        check("hold_word", 32'(snk), 32'(prev_snk));
        check("hold_last", 32'(snk_last), 32'(prev_last));
      end
      hold_pend = snk_valid && !snk_ready;
      prev_snk  = snk;
      prev_last = snk_last;
      if (snk_valid && snk_ready) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_word: got %0h, expected no word", snk);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("word", 32'(snk), 32'(e.w));
          check("last", 32'(snk_last), 32'(e.l));
          if (e.l) fcount--;
          popped++;
        end
      end
      if (net_valid && net_ready) begin
        int unsigned fr;
        fr = 32'(net_out);
`ifdef NETWORK_SINK_TSTAMP_EN
        exp_q.push_back('{w: SW'(ts_m % 256), l: 1'b0});
        ts_m = (ts_m + 1) % 256;
`endif
        for (int k = 0; k < NW; k++)
          exp_q.push_back('{w: SW'((fr / (1 << (k * SW))) % 256), l: (k == NW - 1)});
        fcount++;
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic offer(input logic [NUM_OUT-1:0] f, input int max_cyc, output bit ok);
    ok = 1'b0;
    @(posedge clk); #1;
    net_valid = 1'b1;
    net_out   = f;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (net_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    net_valid = 1'b0;
  endtask

  task automatic send(input logic [NUM_OUT-1:0] f);
    bit ok;
    offer(f, 40, ok);
    check("accept", 32'(ok), 32'd1);
  endtask

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_idle", 32'(snk_valid), 32'd0);
  endtask

  initial begin
    bit ok;
    // 1: reset holds outputs low even with net_valid asserted
    net_valid = 1'b1;
    net_out   = NUM_OUT'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(snk_valid), 32'd0);
    check("rst_snk", 32'(snk), 32'd0);
    check("rst_last", 32'(snk_last), 32'd0);
    check("rst_ready", 32'(net_ready), 32'd0);
    arst = 1'b0;
    net_valid = 1'b0;
    @(posedge clk); #1;
    check("rel_ready", 32'(net_ready), 32'd1);
    mon_en = 1'b1;

    // 2: single frame, first word one cycle after push
    snk_ready = 1'b1;
    send(20'hABCDE);
`ifndef NETWORK_SINK_TSTAMP_EN
    check("lat_valid", 32'(snk_valid), 32'd1);
    check("lat_word0", 32'(snk), 32'h0DE);
    check("lat_last0", 32'(snk_last), 32'd0);
`endif
    drain(20);

    // 3: backpressure fills the FIFO, fifth frame refused
    snk_ready = 1'b0;
    popped = 0;
    for (int i = 0; i < 4; i++) send(NUM_OUT'($urandom));
    offer(NUM_OUT'($urandom), 5, ok);
    check("fifth_refused", 32'(ok), 32'd0);
    check("full_ready", 32'(net_ready), 32'd0);
    @(posedge clk); #1;
    snk_ready = 1'b1;
    drain(60);
    check("bp_words", 32'(popped), 32'(4 * WPF));

    // 4: streaming, one frame every third cycle
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      net_valid = (i % 3 == 0) && (i < 28);
      net_out   = NUM_OUT'($urandom);
      @(negedge clk);
      if (i >= 1 && i < 28) check("stream_valid", 32'(snk_valid), 32'd1);
    end
    @(posedge clk); #1;
    net_valid = 1'b0;
    drain(60);

    // random traffic and backpressure
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      snk_ready = ($urandom % 4) != 0;
      net_valid = ($urandom % 2) != 0;
      net_out   = NUM_OUT'($urandom);
    end
    @(posedge clk); #1;
    net_valid = 1'b0;
    snk_ready = 1'b1;
    drain(100);

    // 5: reset after two words of frame 0 with two more frames queued
    snk_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(NUM_OUT'($urandom));
    snk_ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    snk_ready = 1'b0;
    #2;
    mon_en = 1'b0;
    arst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(snk_valid), 32'd0);
    check("mid_rst_snk", 32'(snk), 32'd0);
    check("mid_rst_last", 32'(snk_last), 32'd0);
    check("mid_rst_ready", 32'(net_ready), 32'd0);
    exp_q.delete();
    fcount = 0;
    ts_m = 0;
    @(posedge clk); #1;
    arst = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    snk_ready = 1'b1;
    send(20'h00001);
`ifndef NETWORK_SINK_TSTAMP_EN
    check("post_rst_word0", 32'(snk), 32'h01);
`endif
    drain(20);

`ifdef NETWORK_SINK_TSTAMP_EN
    // 6: header wrap over 256+ frames
    for (int i = 0; i < 260; i++) send(NUM_OUT'($urandom));
    drain(40);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
